// File: rtl/display_pkg.sv
// Shared text-display definitions: buffer geometry, command codes and controller states.
// Used by the text buffer controller and by the VGA display and color blocks.
package display_pkg;

    localparam int unsigned ROW_CNT  = 3;
    localparam int unsigned ROW_SIZE = 10;

    localparam logic [7:0] CMD_BACKSPACE = 8'hF0;
    localparam logic [7:0] CMD_NEWLINE   = 8'hF1;
    localparam logic [7:0] CMD_CLEAR     = 8'hF2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_SCROLL
    } state_t;

endpackage

// File: rtl/text_buffer_ctrl.sv
// Double-buffered text controller: edits a working glyph buffer from a character stream and
// copies it to the displayed buffer at the start of vertical blanking.
module text_buffer_ctrl #(
    parameter int unsigned ROW_CNT  = display_pkg::ROW_CNT,
    parameter int unsigned ROW_SIZE = display_pkg::ROW_SIZE
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_char_valid,
    input  logic [7:0]                           i_char,
    output logic                                 o_char_ready,
    input  logic                                 i_frame_start,
    output logic [ROW_CNT-1:0][3:0]              o_word_cnt,
    output logic [ROW_CNT-1:0][ROW_SIZE-1:0][7:0] o_pattern_num,
    output logic                                 o_dirty
);

    import display_pkg::*;

    localparam int unsigned RW = (ROW_CNT > 1) ? $clog2(ROW_CNT) : 1;
    localparam int unsigned CW = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROW_CNT - 1);
    localparam logic [3:0]    ROW_FULL = 4'(ROW_SIZE);
    localparam logic [CW-1:0] COL0     = '0;

    state_t        state;
    logic          ready;
    logic [7:0]    char_q;
    logic [RW-1:0] cur_row;
    logic [RW-1:0] scroll_idx;
    logic          pend_glyph;
    logic          commit_pending;

    logic [3:0] wcnt   [ROW_CNT];
    logic [7:0] wglyph [ROW_CNT][ROW_SIZE];

    logic [3:0]    col;
    logic [CW-1:0] col_idx;
    logic [RW-1:0] next_row;
    logic [RW-1:0] prev_row;
    logic [RW-1:0] scroll_src;

    assign col          = wcnt[cur_row];
    assign col_idx      = col[CW-1:0];
    assign next_row     = cur_row + 1'b1;
    assign prev_row     = cur_row - 1'b1;
    assign scroll_src   = scroll_idx + 1'b1;
    assign o_char_ready = ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= S_IDLE;
            ready          <= 1'b0;
            char_q         <= '0;
            cur_row        <= '0;
            scroll_idx     <= '0;
            pend_glyph     <= 1'b0;
            commit_pending <= 1'b0;
            o_dirty        <= 1'b0;
            for (int r = 0; r < ROW_CNT; r++) begin
                wcnt[r]       <= '0;
                o_word_cnt[r] <= '0;
                for (int c = 0; c < ROW_SIZE; c++) begin
                    wglyph[r][c]        <= '0;
                    o_pattern_num[r][c] <= '0;
                end
            end
        end else begin
            unique case (state)
                S_IDLE: begin
                    // Edits only happen in EXEC/SCROLL, so a commit here always sees the
                    // pre-character buffer and leaves nothing dirty.
                    if (i_frame_start || commit_pending) begin
                        commit_pending <= 1'b0;
                        o_dirty        <= 1'b0;
                        for (int r = 0; r < ROW_CNT; r++) begin
                            o_word_cnt[r] <= wcnt[r];
                            for (int c = 0; c < ROW_SIZE; c++) begin
                                o_pattern_num[r][c] <= wglyph[r][c];
                            end
                        end
                    end
                    if (ready && i_char_valid) begin
                        char_q <= i_char;
                        state  <= S_EXEC;
                        ready  <= 1'b0;
                    end else begin
                        ready <= 1'b1;
                    end
                end

                S_EXEC: begin
                    if (i_frame_start) commit_pending <= 1'b1;
                    state <= S_IDLE;
                    ready <= 1'b1;
                    if (char_q[7:6] == 2'b00) begin
                        o_dirty <= 1'b1;
                        if (col < ROW_FULL) begin
                            wglyph[cur_row][col_idx] <= char_q;
                            wcnt[cur_row]            <= col + 4'd1;
                        end else if (cur_row < LAST_ROW) begin
                            cur_row               <= next_row;
                            wglyph[next_row][COL0] <= char_q;
                            wcnt[next_row]        <= 4'd1;
                        end else begin
                            pend_glyph <= 1'b1;
                            scroll_idx <= '0;
                            state      <= S_SCROLL;
                            ready      <= 1'b0;
                        end
                    end else if (char_q == CMD_BACKSPACE) begin
                        // Stepping back over a row break only moves the cursor; the row it
                        // leaves is empty by construction.
                        if (col != 4'd0) begin
                            wglyph[cur_row][col_idx - 1'b1] <= '0;
                            wcnt[cur_row]                   <= col - 4'd1;
                            o_dirty                         <= 1'b1;
                        end else if (cur_row != '0) begin
                            cur_row <= prev_row;
                        end
                    end else if (char_q == CMD_NEWLINE) begin
                        if (cur_row < LAST_ROW) begin
                            cur_row <= next_row;
                        end else begin
                            pend_glyph <= 1'b0;
                            scroll_idx <= '0;
                            state      <= S_SCROLL;
                            ready      <= 1'b0;
                        end
                    end else if (char_q == CMD_CLEAR) begin
                        cur_row <= '0;
                        o_dirty <= 1'b1;
                        for (int r = 0; r < ROW_CNT; r++) begin
                            wcnt[r] <= '0;
                            for (int c = 0; c < ROW_SIZE; c++) begin
                                wglyph[r][c] <= '0;
                            end
                        end
                    end
                end

                S_SCROLL: begin
                    if (i_frame_start) commit_pending <= 1'b1;
                    o_dirty <= 1'b1;
                    if (scroll_idx != LAST_ROW) begin
                        wcnt[scroll_idx] <= wcnt[scroll_src];
                        for (int c = 0; c < ROW_SIZE; c++) begin
                            wglyph[scroll_idx][c] <= wglyph[scroll_src][c];
                        end
                        scroll_idx <= scroll_src;
                    end else begin
                        for (int c = 0; c < ROW_SIZE; c++) begin
                            wglyph[LAST_ROW][c] <= '0;
                        end
                        if (pend_glyph) begin
                            wglyph[LAST_ROW][COL0] <= char_q;
                            wcnt[LAST_ROW]         <= 4'd1;
                        end else begin
                            wcnt[LAST_ROW] <= 4'd0;
                        end
                        pend_glyph <= 1'b0;
                        state      <= S_IDLE;
                        ready      <= 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
